// File: rtl/div_sqrt_iter_engine.sv
// div_sqrt_iter_engine
//   Multi-cycle mantissa divide / square-root engine built from a chain of
//   ITER_PER_CYCLE non-restoring iteration stages. It sits behind a start/done
//   handshake and produces a WIDTH-bit truncated result plus a sticky bit.
//
//   Divide : Result = floor((A << (WIDTH-1)) / B)
//   Sqrt   : Result = floor(sqrt(A << (WIDTH-1+Odd)))
//
// Ports
//   Clk_CI     clock
//   Rst_RBI    asynchronous active-low reset
//   Start_SI   start request, accepted while Ready_SO=1 and Kill_SI=0
//   Op_SI      0 = divide, 1 = square root (sampled at accept)
//   Odd_SI     sqrt only: odd exponent, radicand shifted one extra bit
//   Kill_SI    abort any operation in flight (wins over Start_SI)
//   A_DI       dividend / radicand, MSB set
//   B_DI       divisor, MSB set (ignored for sqrt)
//   Ready_SO   engine idle and able to accept a start
//   Busy_SO    operation in flight (~Ready_SO)
//   Done_SO    one-cycle pulse, Result_DO/Sticky_DO freshly updated
//   Result_DO  quotient or root, held until the next completed operation
//   Sticky_DO  final remainder nonzero
//
// Configuration macro
//   FPU_DIVSQRT_STICKY_EN : when defined, the remainder correction and
//   zero-detect are built; otherwise Sticky_DO is tied to 0. The FIX state
//   exists in both builds so latency is identical.

module div_sqrt_iter_engine #(
  parameter int unsigned WIDTH          = 24,
  parameter int unsigned ITER_PER_CYCLE = 2
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             Start_SI,
  input  logic             Op_SI,
  input  logic             Odd_SI,
  input  logic             Kill_SI,
  input  logic [WIDTH-1:0] A_DI,
  input  logic [WIDTH-1:0] B_DI,
  output logic             Ready_SO,
  output logic             Busy_SO,
  output logic             Done_SO,
  output logic [WIDTH-1:0] Result_DO,
  output logic             Sticky_DO
);

  localparam int unsigned N  = WIDTH / ITER_PER_CYCLE;
  localparam int unsigned RW = WIDTH + 3;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  if (ITER_PER_CYCLE < 1 || ITER_PER_CYCLE > 4 || (WIDTH % ITER_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("div_sqrt_iter_engine: ITER_PER_CYCLE must be 1..4 and divide WIDTH");
  end

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [RW-1:0]      rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [2*WIDTH-1:0] rad_q, rad_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               sticky_q, sticky_d;
  logic               done_q, done_d;

  logic [RW-1:0]      iterRem;
  logic [WIDTH-1:0]   iterQuo;
  logic [2*WIDTH-1:0] iterRad;
  logic [RW-1:0]      shifted;
  logic [RW-1:0]      trial;
  logic               qBit;
  logic               fixSticky;

  // Iteration chain. The partial remainder is a two's complement value of
  // RW bits; its MSB is the sign that picks add vs. subtract for the next
  // stage. Modulo-RW arithmetic is exact because every true intermediate
  // remainder fits in RW signed bits.
  //   Divide : remainder register holds 2*s (shift applied after the step),
  //            so the first step compares A directly against B.
  //   Sqrt   : remainder register holds R; each step brings in the next
  //            2-bit radicand digit and adds/subtracts 4Q+3 / 4Q+1, the low
  //            "11"/"01" being the carry-in tied to the digit position.
  always_comb begin
    iterRem = rem_q;
    iterQuo = quo_q;
    iterRad = rad_q;
    shifted = '0;
    trial   = '0;
    qBit    = 1'b0;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      if (op_q) begin
        shifted = {iterRem[RW-3:0], iterRad[2*WIDTH-1 -: 2]};
        if (iterRem[RW-1]) begin
          trial = shifted + {1'b0, iterQuo, 2'b11};
        end else begin
          trial = shifted - {1'b0, iterQuo, 2'b01};
        end
        iterRad = iterRad << 2;
      end else begin
        if (iterRem[RW-1]) begin
          trial = iterRem + {3'b000, b_q};
        end else begin
          trial = iterRem - {3'b000, b_q};
        end
      end
      qBit    = ~trial[RW-1];
      iterQuo = {iterQuo[WIDTH-2:0], qBit};
      iterRem = op_q ? trial : {trial[RW-2:0], 1'b0};
    end
  end

`ifdef FPU_DIVSQRT_STICKY_EN
  logic [RW-1:0] fixRem;

  // Final remainder: undo the divide's post-step doubling, then add back the
  // divisor (or 2Q+1 for sqrt) when the non-restoring remainder ended
  // negative. Only the remainder is corrected; the truncated result is
  // already exact.
  always_comb begin
    fixRem = op_q ? rem_q : {rem_q[RW-1], rem_q[RW-1:1]};
    if (fixRem[RW-1]) begin
      fixRem = fixRem + (op_q ? {2'b00, quo_q, 1'b1} : {3'b000, b_q});
    end
    fixSticky = |fixRem;
  end
`else
  assign fixSticky = 1'b0;
`endif

  // Control and next-state selection. Kill is applied last so it overrides
  // any start, iteration or writeback decided above.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    rad_d    = rad_q;
    res_d    = res_q;
    sticky_d = sticky_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start_SI && !Kill_SI) begin
          op_d    = Op_SI;
          b_d     = B_DI;
          quo_d   = '0;
          cnt_d   = '0;
          rem_d   = Op_SI ? '0 : {3'b000, A_DI};
          rad_d   = {(Odd_SI ? {A_DI, 1'b0} : {1'b0, A_DI}), {(WIDTH-1){1'b0}}};
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        rem_d = iterRem;
        quo_d = iterQuo;
        rad_d = iterRad;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        res_d    = quo_q;
        sticky_d = fixSticky;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (Kill_SI) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      res_d    = res_q;
      sticky_d = sticky_q;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      rad_q    <= '0;
      res_q    <= '0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      rad_q    <= rad_d;
      res_q    <= res_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
    end
  end

  assign Ready_SO  = (state_q == S_IDLE);
  assign Busy_SO   = ~Ready_SO;
  assign Done_SO   = done_q;
  assign Result_DO = res_q;
  assign Sticky_DO = sticky_q;

endmodule

// File: tb/tb_div_sqrt_iter_engine.sv
// tb_div_sqrt_iter_engine
//   Self-checking bench for div_sqrt_iter_engine (WIDTH=24, ITER_PER_CYCLE=2).
//   Directed cases check handshake timing, kill and reset behaviour; random
//   normalised operands are compared against an arithmetic reference model.

module tb_div_sqrt_iter_engine;

  localparam int W   = 24;
  localparam int IPC = 2;
  localparam int N   = W / IPC;
  localparam int LAT = N + 2;
  localparam int NUM_RANDOM = 3000;

  logic         Clk_CI = 1'b0;
  logic         Rst_RBI;
  logic         Start_SI;
  logic         Op_SI;
  logic         Odd_SI;
  logic         Kill_SI;
  logic [W-1:0] A_DI;
  logic [W-1:0] B_DI;
  logic         Ready_SO;
  logic         Busy_SO;
  logic         Done_SO;
  logic [W-1:0] Result_DO;
  logic         Sticky_DO;

  int checkCount = 0;
  int passCount  = 0;

  logic [W-1:0] lastResult;
  logic         lastSticky;

  div_sqrt_iter_engine #(.WIDTH(W), .ITER_PER_CYCLE(IPC)) dut (
    .Clk_CI    (Clk_CI),
    .Rst_RBI   (Rst_RBI),
    .Start_SI  (Start_SI),
    .Op_SI     (Op_SI),
    .Odd_SI    (Odd_SI),
    .Kill_SI   (Kill_SI),
    .A_DI      (A_DI),
    .B_DI      (B_DI),
    .Ready_SO  (Ready_SO),
    .Busy_SO   (Busy_SO),
    .Done_SO   (Done_SO),
    .Result_DO (Result_DO),
    .Sticky_DO (Sticky_DO)
  );

  always #5 Clk_CI = ~Clk_CI;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sticky is only produced when the feature is built in.
  function automatic logic stickyExpect(input logic s);
`ifdef FPU_DIVSQRT_STICKY_EN
    return s;
`else
    return 1'b0 & s;
`endif
  endfunction

  // Reference model from the arithmetic definition: integer division and an
  // integer square root refined from a floating-point estimate.
  function automatic void refModel(input logic op, input logic odd, input logic [W-1:0] a,
                                   input logic [W-1:0] b, output logic [W-1:0] res, output logic sticky);
    longint unsigned x, q, r;
    real rx;
    if (!op) begin
      x = 64'(a) << (W-1);
      q = x / 64'(b);
      r = x % 64'(b);
    end else begin
      x = 64'(a) << (W-1+(odd ? 1 : 0));
      rx = x;
      q = 64'($rtoi($sqrt(rx)));
      while (q*q > x) q--;
      while ((q+1)*(q+1) <= x) q++;
      r = x - q*q;
    end
    res = q[W-1:0];
    sticky = (r != 0);
  endfunction

  // Issue one operation from the current cycle and wait (bounded) for Done.
  // Operand inputs are scrambled after accept; optionally a stray Start is
  // pulsed during ITER.
  task automatic applyStimulus(input logic op, input logic odd, input logic [W-1:0] a,
                               input logic [W-1:0] b, input bit midStart,
                               output int cycles, output bit gotDone);
    Start_SI = 1'b1;
    Op_SI    = op;
    Odd_SI   = odd;
    A_DI     = a;
    B_DI     = b;
    @(posedge Clk_CI); #1;
    Start_SI = 1'b0;
    Op_SI    = 1'($urandom);
    Odd_SI   = 1'($urandom);
    A_DI     = W'($urandom);
    B_DI     = W'($urandom);
    checkOutput("busy_after_accept", 64'(Busy_SO), 64'd1);
    checkOutput("done_low_after_accept", 64'(Done_SO), 64'd0);
    cycles  = 1;
    gotDone = 1'b0;
    while (!gotDone && cycles < LAT + 20) begin
      if (Done_SO) begin
        gotDone = 1'b1;
      end else begin
        Start_SI = (midStart && cycles == 3);
        @(posedge Clk_CI); #1;
        cycles++;
      end
    end
    Start_SI = 1'b0;
  endtask

  task automatic runCheck(input string tag, input logic op, input logic odd, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit midStart,
                          input logic [W-1:0] expRes, input logic expSticky);
    int cycles;
    bit gotDone;
    applyStimulus(op, odd, a, b, midStart, cycles, gotDone);
    checkOutput({tag, "_done_seen"}, 64'(gotDone), 64'd1);
    checkOutput({tag, "_latency"}, 64'(cycles), 64'(LAT));
    checkOutput({tag, "_ready_in_done"}, 64'(Ready_SO), 64'd1);
    checkOutput({tag, "_result"}, 64'(Result_DO), 64'(expRes));
    checkOutput({tag, "_sticky"}, 64'(Sticky_DO), 64'(stickyExpect(expSticky)));
    lastResult = expRes;
    lastSticky = stickyExpect(expSticky);
  endtask

  initial begin
    bit sawDone;
    logic [W-1:0] ra, rb, er;
    logic rop, rodd, es;

    Rst_RBI  = 1'b0;
    Start_SI = 1'b0;
    Op_SI    = 1'b0;
    Odd_SI   = 1'b0;
    Kill_SI  = 1'b0;
    A_DI     = '0;
    B_DI     = '0;
    repeat (3) @(posedge Clk_CI);
    #1;
    checkOutput("reset_ready", 64'(Ready_SO), 64'd1);
    checkOutput("reset_busy", 64'(Busy_SO), 64'd0);
    checkOutput("reset_done", 64'(Done_SO), 64'd0);
    checkOutput("reset_result", 64'(Result_DO), 64'd0);
    checkOutput("reset_sticky", 64'(Sticky_DO), 64'd0);
    Rst_RBI = 1'b1;
    @(posedge Clk_CI); #1;

    $display("[TB] directed divide and sqrt cases");
    runCheck("div_1_1", 1'b0, 1'b0, 24'h800000, 24'h800000, 1'b0, 24'h800000, 1'b0);
    @(posedge Clk_CI); #1;
    checkOutput("done_one_cycle", 64'(Done_SO), 64'd0);
    runCheck("div_1_1p5", 1'b0, 1'b0, 24'h800000, 24'hC00000, 1'b0, 24'h555555, 1'b1);
    runCheck("div_1p5_1", 1'b0, 1'b0, 24'hC00000, 24'h800000, 1'b0, 24'hC00000, 1'b0);
    runCheck("sqrt_even", 1'b1, 1'b0, 24'h800000, 24'h123456, 1'b0, 24'h800000, 1'b0);
    runCheck("sqrt_odd", 1'b1, 1'b1, 24'h800000, 24'h000000, 1'b0, 24'hB504F3, 1'b1);

    $display("[TB] kill in 5th ITER cycle");
    @(posedge Clk_CI); #1;
    Start_SI = 1'b1; Op_SI = 1'b0; Odd_SI = 1'b0; A_DI = 24'hC00000; B_DI = 24'h800000;
    @(posedge Clk_CI); #1;
    Start_SI = 1'b0;
    repeat (4) @(posedge Clk_CI);
    #1;
    Kill_SI = 1'b1;
    @(posedge Clk_CI); #1;
    Kill_SI = 1'b0;
    checkOutput("kill_ready", 64'(Ready_SO), 64'd1);
    checkOutput("kill_busy", 64'(Busy_SO), 64'd0);
    sawDone = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      if (Done_SO) sawDone = 1'b1;
      @(posedge Clk_CI); #1;
    end
    checkOutput("kill_no_done", 64'(sawDone), 64'd0);
    checkOutput("kill_result_held", 64'(Result_DO), 64'(lastResult));
    checkOutput("kill_sticky_held", 64'(Sticky_DO), 64'(lastSticky));

    $display("[TB] kill together with start");
    Start_SI = 1'b1; Kill_SI = 1'b1; Op_SI = 1'b0; A_DI = 24'hC00000; B_DI = 24'h800000;
    @(posedge Clk_CI); #1;
    Start_SI = 1'b0; Kill_SI = 1'b0;
    checkOutput("killstart_ready", 64'(Ready_SO), 64'd1);
    sawDone = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      if (Done_SO) sawDone = 1'b1;
      @(posedge Clk_CI); #1;
    end
    checkOutput("killstart_no_done", 64'(sawDone), 64'd0);
    checkOutput("killstart_result_held", 64'(Result_DO), 64'(lastResult));

    $display("[TB] back-to-back with stray start during ITER");
    runCheck("b2b_first", 1'b0, 1'b0, 24'h800000, 24'hC00000, 1'b0, 24'h555555, 1'b1);
    runCheck("b2b_second", 1'b1, 1'b1, 24'h800000, 24'h000000, 1'b1, 24'hB504F3, 1'b1);
    sawDone = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge Clk_CI); #1;
      if (Done_SO) sawDone = 1'b1;
    end
    checkOutput("stray_start_ignored", 64'(sawDone), 64'd0);

    $display("[TB] reset mid-ITER");
    Start_SI = 1'b1; Op_SI = 1'b0; A_DI = 24'hC00000; B_DI = 24'h800000;
    @(posedge Clk_CI); #1;
    Start_SI = 1'b0;
    repeat (5) @(posedge Clk_CI);
    #1;
    Rst_RBI = 1'b0;
    #1;
    checkOutput("midrst_ready", 64'(Ready_SO), 64'd1);
    checkOutput("midrst_busy", 64'(Busy_SO), 64'd0);
    checkOutput("midrst_done", 64'(Done_SO), 64'd0);
    checkOutput("midrst_result", 64'(Result_DO), 64'd0);
    checkOutput("midrst_sticky", 64'(Sticky_DO), 64'd0);
    @(posedge Clk_CI); #1;
    Rst_RBI = 1'b1;
    @(posedge Clk_CI); #1;

    $display("[TB] random operands against reference model");
    for (int n = 0; n < NUM_RANDOM; n++) begin
      rop  = 1'($urandom);
      rodd = 1'($urandom);
      ra   = W'($urandom) | {1'b1, {(W-1){1'b0}}};
      rb   = W'($urandom) | {1'b1, {(W-1){1'b0}}};
      refModel(rop, rodd, ra, rb, er, es);
      runCheck(rop ? "rand_sqrt" : "rand_div", rop, rodd, ra, rb, 1'b0, er, es);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
